// File: rtl/core_pkg.sv
// core_pkg -- shared types for the memory-access stage.
//   t_xlen       : 32-bit datapath word
//   F3_*         : func3 load/store width and sign encodings
//   t_mem_state  : memory-access FSM states
package core_pkg;

  localparam int unsigned XLEN_W = 32;

  typedef logic [XLEN_W-1:0] t_xlen;

  localparam logic [2:0] F3_B  = 3'b000;  // LB / SB
  localparam logic [2:0] F3_H  = 3'b001;  // LH / SH
  localparam logic [2:0] F3_W  = 3'b010;  // LW / SW
  localparam logic [2:0] F3_BU = 3'b100;  // LBU
  localparam logic [2:0] F3_HU = 3'b101;  // LHU

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } t_mem_state;

endpackage

// File: rtl/mem_align.sv
// mem_align -- combinational byte-lane logic for the memory-access stage.
//   func3      in  load/store width and sign code
//   addr_lo    in  low two bits of the effective address
//   store_data in  raw rs2 store data
//   load_data  in  raw word returned by data memory
//   be         out byte enables for a store (0001<<a, 0011<<{a[1],0}, 1111)
//   wdata      out store data replicated across lanes
//   load_value out extracted and sign/zero-extended load result
// Halfword/word selection ignores the sub-alignment bits, so misaligned
// accesses are forced to their natural boundary.
import core_pkg::*;

module mem_align (
  input  logic [2:0] func3,
  input  logic [1:0] addr_lo,
  input  t_xlen      store_data,
  input  t_xlen      load_data,
  output logic [3:0] be,
  output t_xlen      wdata,
  output t_xlen      load_value
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    be    = 4'b1111;
    wdata = store_data;
    case (func3[1:0])
      2'b00: begin
        be    = 4'b0001 << addr_lo;
        wdata = {4{store_data[7:0]}};
      end
      2'b01: begin
        be    = 4'b0011 << {addr_lo[1], 1'b0};
        wdata = {2{store_data[15:0]}};
      end
      default: begin
        be    = 4'b1111;
        wdata = store_data;
      end
    endcase
  end

  always_comb begin
    byte_sel = load_data[7:0];
    case (addr_lo)
      2'd0:    byte_sel = load_data[7:0];
      2'd1:    byte_sel = load_data[15:8];
      2'd2:    byte_sel = load_data[23:16];
      default: byte_sel = load_data[31:24];
    endcase
    half_sel = addr_lo[1] ? load_data[31:16] : load_data[15:0];
  end

  always_comb begin
    load_value = load_data;
    case (func3)
      F3_B:    load_value = {{24{byte_sel[7]}}, byte_sel};
      F3_BU:   load_value = {24'd0, byte_sel};
      F3_H:    load_value = {{16{half_sel[15]}}, half_sel};
      F3_HU:   load_value = {16'd0, half_sel};
      default: load_value = load_data;
    endcase
  end

endmodule

// File: rtl/mem_access.sv
// mem_access -- Memory stage (Ps4 -> Ps5) with a data-memory handshake.
//   clk, rst                     clock, synchronous active-high reset
//   Data_alu_Ps4                 ALU result / effective address
//   Data_store_Ps4               rs2 store data
//   Ctrl_func3_Ps4, Ctrl_rd_Ps4  width/sign code, destination register
//   Ctrl_load/store/wb_en_Ps4    op-type flags and writeback enable
//   dmem_req_valid/ready         request handshake
//   dmem_we/addr/be/wdata        request payload (addr word-aligned)
//   dmem_rsp_valid/rdata         load response
//   Stall_Ps4                    holds upstream while an access is pending
//   Data_wb_Ps5, Ctrl_rd_Ps5,
//   Ctrl_wb_en_Ps5, Fault_Ps5    registered results to Writeback
// Build option: MEM_MISALIGN_TRAP_EN -- misaligned halfword/word accesses
// fault instead of being forced to alignment.
import core_pkg::*;

module mem_access #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] Data_alu_Ps4,
  input  logic [XLEN-1:0] Data_store_Ps4,
  input  logic [2:0]      Ctrl_func3_Ps4,
  input  logic [4:0]      Ctrl_rd_Ps4,
  input  logic            Ctrl_load_Ps4,
  input  logic            Ctrl_store_Ps4,
  input  logic            Ctrl_wb_en_Ps4,
  output logic            dmem_req_valid,
  input  logic            dmem_req_ready,
  output logic            dmem_we,
  output logic [XLEN-1:0] dmem_addr,
  output logic [3:0]      dmem_be,
  output logic [XLEN-1:0] dmem_wdata,
  input  logic            dmem_rsp_valid,
  input  logic [XLEN-1:0] dmem_rdata,
  output logic            Stall_Ps4,
  output logic [XLEN-1:0] Data_wb_Ps5,
  output logic [4:0]      Ctrl_rd_Ps5,
  output logic            Ctrl_wb_en_Ps5,
  output logic            Fault_Ps5
);

  t_mem_state state, state_next;

  // Access captured on entry to REQ; upstream holds Ps4 but we do not rely on it.
  t_xlen      addr_q;
  t_xlen      sdata_q;
  logic [2:0] f3_q;
  logic [4:0] rd_q;
  logic       wb_en_q;
  logic       store_q;

  logic       mem_op, legal_f3, misaligned, bad_op, accept, completion, in_req;
  logic [3:0] be_raw;
  t_xlen      wdata_raw, load_value;

  assign mem_op = Ctrl_load_Ps4 | Ctrl_store_Ps4;

  always_comb begin
    legal_f3 = 1'b0;
    if (Ctrl_store_Ps4)
      legal_f3 = (Ctrl_func3_Ps4 inside {F3_B, F3_H, F3_W});
    else if (Ctrl_load_Ps4)
      legal_f3 = (Ctrl_func3_Ps4 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
  end

`ifdef MEM_MISALIGN_TRAP_EN
  assign misaligned = ((Ctrl_func3_Ps4[1:0] == 2'b01) && Data_alu_Ps4[0]) ||
                      ((Ctrl_func3_Ps4[1:0] == 2'b10) && (Data_alu_Ps4[1:0] != 2'b00));
`else
  assign misaligned = 1'b0;
`endif

  assign bad_op = mem_op & ((Ctrl_load_Ps4 & Ctrl_store_Ps4) | ~legal_f3 | misaligned);
  assign accept = (state == IDLE) & mem_op & ~bad_op;

  always_comb begin
    state_next = state;
    completion = 1'b0;
    case (state)
      IDLE: if (accept) state_next = REQ;
      REQ: begin
        if (dmem_req_ready) begin
          if (store_q) begin
            state_next = IDLE;
            completion = 1'b1;
          end else begin
            state_next = WAIT;
          end
        end
      end
      WAIT: begin
        if (dmem_rsp_valid) begin
          state_next = IDLE;
          completion = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Combinational outputs are forced low while reset is asserted.
  assign Stall_Ps4      = ~rst & ~completion & ((state != IDLE) | accept);
  assign in_req         = ~rst & (state == REQ);
  assign dmem_req_valid = in_req;
  assign dmem_we        = in_req & store_q;
  assign dmem_addr      = in_req ? {addr_q[XLEN-1:2], 2'b00} : '0;
  assign dmem_be        = in_req ? be_raw : '0;
  assign dmem_wdata     = in_req ? wdata_raw : '0;

  mem_align u_align (
    .func3      (f3_q),
    .addr_lo    (addr_q[1:0]),
    .store_data (sdata_q),
    .load_data  (dmem_rdata),
    .be         (be_raw),
    .wdata      (wdata_raw),
    .load_value (load_value)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      addr_q         <= '0;
      sdata_q        <= '0;
      f3_q           <= '0;
      rd_q           <= '0;
      wb_en_q        <= 1'b0;
      store_q        <= 1'b0;
      Data_wb_Ps5    <= '0;
      Ctrl_rd_Ps5    <= '0;
      Ctrl_wb_en_Ps5 <= 1'b0;
      Fault_Ps5      <= 1'b0;
    end else begin
      state          <= state_next;
      Ctrl_wb_en_Ps5 <= 1'b0;
      Fault_Ps5      <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            addr_q  <= Data_alu_Ps4;
            sdata_q <= Data_store_Ps4;
            f3_q    <= Ctrl_func3_Ps4;
            rd_q    <= Ctrl_rd_Ps4;
            wb_en_q <= Ctrl_wb_en_Ps4;
            store_q <= Ctrl_store_Ps4;
          end else if (bad_op) begin
            Fault_Ps5 <= 1'b1;
          end else begin
            Data_wb_Ps5    <= Data_alu_Ps4;
            Ctrl_rd_Ps5    <= Ctrl_rd_Ps4;
            Ctrl_wb_en_Ps5 <= Ctrl_wb_en_Ps4;
          end
        end
        WAIT: begin
          if (dmem_rsp_valid) begin
            Data_wb_Ps5    <= load_value;
            Ctrl_rd_Ps5    <= rd_q;
            Ctrl_wb_en_Ps5 <= wb_en_q;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access.sv
`timescale 1ns/1ps
module tb_mem_access;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] alu = '0, sdata = '0;
  logic [2:0]  f3 = '0;
  logic [4:0]  rd = '0;
  logic        load = 1'b0, store = 1'b0, wb_en = 1'b0;
  logic        dmem_req_valid, dmem_req_ready = 1'b0, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata = '0;
  logic [3:0]  dmem_be;
  logic        dmem_rsp_valid = 1'b0;
  logic        stall;
  logic [31:0] data_wb;
  logic [4:0]  rd5;
  logic        wb_en5, fault5;

  int unsigned tests = 0;
  int unsigned fails = 0;

  always #5 clk = ~clk;

  mem_access #(.XLEN(32)) dut (
    .clk(clk), .rst(rst),
    .Data_alu_Ps4(alu), .Data_store_Ps4(sdata), .Ctrl_func3_Ps4(f3), .Ctrl_rd_Ps4(rd),
    .Ctrl_load_Ps4(load), .Ctrl_store_Ps4(store), .Ctrl_wb_en_Ps4(wb_en),
    .dmem_req_valid(dmem_req_valid), .dmem_req_ready(dmem_req_ready), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_be(dmem_be), .dmem_wdata(dmem_wdata),
    .dmem_rsp_valid(dmem_rsp_valid), .dmem_rdata(dmem_rdata),
    .Stall_Ps4(stall), .Data_wb_Ps5(data_wb), .Ctrl_rd_Ps5(rd5),
    .Ctrl_wb_en_Ps5(wb_en5), .Fault_Ps5(fault5)
  );

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "timeout");
  end

  // ---------------- reference model ----------------
  function automatic logic [3:0] exp_be(input logic [2:0] f, input logic [31:0] a);
    if (f % 4 == 0) return 4'(1 << (a % 4));
    if (f % 4 == 1) return 4'(3 << (a & 2));
    return 4'hF;
  endfunction

  function automatic logic [31:0] exp_wdata(input logic [2:0] f, input logic [31:0] d);
    logic [31:0] b, h;
    b = d & 32'hFF;
    h = d & 32'hFFFF;
    if (f % 4 == 0) return b * 32'h01010101;
    if (f % 4 == 1) return h * 32'h00010001;
    return d;
  endfunction

  function automatic logic [31:0] exp_load(input logic [2:0] f, input logic [31:0] a, input logic [31:0] d);
    logic [31:0] v;
    int unsigned sh;
    v = d;
    if (f == 3'd0 || f == 3'd4) begin
      sh = (a % 4) * 8;
      v = (d >> sh) & 32'hFF;
      if (f == 3'd0 && v >= 32'h80) v = v - 32'h100;
    end else if (f == 3'd1 || f == 3'd5) begin
      sh = (a & 2) * 8;
      v = (d >> sh) & 32'hFFFF;
      if (f == 3'd1 && v >= 32'h8000) v = v - 32'h10000;
    end
    return v;
  endfunction

  function automatic logic exp_fault(input logic ld, input logic st, input logic [2:0] f, input logic [31:0] a);
    if (!ld && !st) return 1'b0;
    if (ld && st) return 1'b1;
    if (st && f > 3'd2) return 1'b1;
    if (ld && (f == 3'd3 || f == 3'd6 || f == 3'd7)) return 1'b1;
`ifdef MEM_MISALIGN_TRAP_EN
    if ((f == 3'd1 || f == 3'd5) && (a % 2 != 0)) return 1'b1;
    if (f == 3'd2 && (a % 4 != 0)) return 1'b1;
`endif
    return 1'b0;
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    load = 1'b0; store = 1'b0; wb_en = 1'b0; f3 = '0; alu = '0; sdata = '0; rd = '0;
  endtask

  task automatic drive_op(input logic ld, input logic st, input logic [2:0] f, input logic [31:0] a,
                          input logic [31:0] sd, input logic [4:0] r, input logic we);
    load = ld; store = st; f3 = f; alu = a; sdata = sd; rd = r; wb_en = we;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset;
    rst = 1'b1;
    drive_op(1'b1, 1'b0, 3'd2, 32'h10, 32'h0, 5'd1, 1'b1);
    dmem_req_ready = 1'b1; dmem_rsp_valid = 1'b1;
    tick; tick;
    tests++; if (stall !== 1'b0) begin fails++; $display("FAIL reset_stall got=%b exp=0", stall); end
    tests++; if (dmem_req_valid !== 1'b0) begin fails++; $display("FAIL reset_req_valid got=%b exp=0", dmem_req_valid); end
    tests++; if ({dmem_we, dmem_addr, dmem_be, dmem_wdata} !== '0) begin fails++; $display("FAIL reset_dmem got=%b/%h/%b/%h exp=0", dmem_we, dmem_addr, dmem_be, dmem_wdata); end
    tests++; if ({data_wb, rd5, wb_en5, fault5} !== '0) begin fails++; $display("FAIL reset_ps5 got=%h/%0d/%b/%b exp=0", data_wb, rd5, wb_en5, fault5); end
    rst = 1'b0; idle_inputs; dmem_req_ready = 1'b0; dmem_rsp_valid = 1'b0;
    tick;
  endtask

  task automatic test_non_mem;
    drive_op(1'b0, 1'b0, 3'd0, 32'h1234, 32'h0, 5'd5, 1'b1);
    #1;
    tests++; if (stall !== 1'b0) begin fails++; $display("FAIL nonmem_stall got=%b exp=0", stall); end
    tick;
    tests++; if (data_wb !== 32'h1234) begin fails++; $display("FAIL nonmem_data got=%h exp=00001234", data_wb); end
    tests++; if (rd5 !== 5'd5) begin fails++; $display("FAIL nonmem_rd got=%0d exp=5", rd5); end
    tests++; if (wb_en5 !== 1'b1) begin fails++; $display("FAIL nonmem_wb_en got=%b exp=1", wb_en5); end
    tests++; if (stall !== 1'b0) begin fails++; $display("FAIL nonmem_stall2 got=%b exp=0", stall); end
    idle_inputs;
    tick;
    tests++; if (wb_en5 !== 1'b0) begin fails++; $display("FAIL nonmem_wb_en_clear got=%b exp=0", wb_en5); end
  endtask

  task automatic test_sb;
    dmem_req_ready = 1'b1;
    drive_op(1'b0, 1'b1, 3'd0, 32'h103, 32'hAB, 5'd7, 1'b0);
    #1;
    tests++; if (stall !== 1'b1) begin fails++; $display("FAIL sb_stall_idle got=%b exp=1", stall); end
    tests++; if (dmem_req_valid !== 1'b0) begin fails++; $display("FAIL sb_req_early got=%b exp=0", dmem_req_valid); end
    tick;
    tests++; if (dmem_req_valid !== 1'b1 || dmem_we !== 1'b1) begin fails++; $display("FAIL sb_req got=%b/%b exp=1/1", dmem_req_valid, dmem_we); end
    tests++; if (dmem_addr !== 32'h100) begin fails++; $display("FAIL sb_addr got=%h exp=00000100", dmem_addr); end
    tests++; if (dmem_be !== 4'b1000) begin fails++; $display("FAIL sb_be got=%b exp=1000", dmem_be); end
    tests++; if (dmem_wdata !== 32'hABABABAB) begin fails++; $display("FAIL sb_wdata got=%h exp=abababab", dmem_wdata); end
    tests++; if (stall !== 1'b0) begin fails++; $display("FAIL sb_stall_done got=%b exp=0", stall); end
    tick;
    idle_inputs; dmem_req_ready = 1'b0;
    #1;
    tests++; if (wb_en5 !== 1'b0 || fault5 !== 1'b0) begin fails++; $display("FAIL sb_bubble got=%b/%b exp=0/0", wb_en5, fault5); end
    tests++; if (dmem_req_valid !== 1'b0) begin fails++; $display("FAIL sb_req_after got=%b exp=0", dmem_req_valid); end
  endtask

  task automatic test_lh;
    logic [2:0]  fs [2];
    logic [31:0] ex [2];
    fs[0] = 3'd1; ex[0] = 32'hFFFF8001;
    fs[1] = 3'd5; ex[1] = 32'h00008001;
    for (int k = 0; k < 2; k++) begin
      drive_op(1'b1, 1'b0, fs[k], 32'h102, 32'h0, 5'd9, 1'b1);
      dmem_req_ready = 1'b1;
      #1;
      tests++; if (stall !== 1'b1) begin fails++; $display("FAIL lh%0d_stall_idle got=%b exp=1", k, stall); end
      tick;
      tests++; if (dmem_req_valid !== 1'b1 || dmem_we !== 1'b0 || dmem_addr !== 32'h100) begin fails++; $display("FAIL lh%0d_req got=%b/%b/%h exp=1/0/00000100", k, dmem_req_valid, dmem_we, dmem_addr); end
      tests++; if (stall !== 1'b1) begin fails++; $display("FAIL lh%0d_stall_req got=%b exp=1", k, stall); end
      tick;
      for (int i = 0; i < 2; i++) begin
        tests++; if (stall !== 1'b1 || dmem_req_valid !== 1'b0 || wb_en5 !== 1'b0) begin fails++; $display("FAIL lh%0d_wait%0d got=%b/%b/%b exp=1/0/0", k, i, stall, dmem_req_valid, wb_en5); end
        tick;
      end
      dmem_req_ready = 1'b0;
      dmem_rsp_valid = 1'b1; dmem_rdata = 32'h80010000;
      #1;
      tests++; if (stall !== 1'b0) begin fails++; $display("FAIL lh%0d_stall_rsp got=%b exp=0", k, stall); end
      tick;
      dmem_rsp_valid = 1'b0; idle_inputs;
      tests++; if (data_wb !== ex[k]) begin fails++; $display("FAIL lh%0d_data got=%h exp=%h", k, data_wb, ex[k]); end
      tests++; if (rd5 !== 5'd9 || wb_en5 !== 1'b1) begin fails++; $display("FAIL lh%0d_wb got=%0d/%b exp=9/1", k, rd5, wb_en5); end
    end
    tick;
  endtask

  task automatic test_backpressure;
    dmem_req_ready = 1'b0;
    drive_op(1'b0, 1'b1, 3'd2, 32'h44, 32'h11223344, 5'd2, 1'b0);
    tick;
    for (int i = 0; i < 3; i++) begin
      dmem_rsp_valid = 1'b1; dmem_rdata = $urandom;
      #1;
      tests++; if (dmem_req_valid !== 1'b1 || dmem_we !== 1'b1 || dmem_addr !== 32'h44 || dmem_be !== 4'hF || dmem_wdata !== 32'h11223344)
        begin fails++; $display("FAIL bp_hold%0d got=%b/%b/%h/%b/%h exp=1/1/00000044/1111/11223344", i, dmem_req_valid, dmem_we, dmem_addr, dmem_be, dmem_wdata); end
      tests++; if (stall !== 1'b1) begin fails++; $display("FAIL bp_stall%0d got=%b exp=1", i, stall); end
      tick;
    end
    dmem_rsp_valid = 1'b0; dmem_req_ready = 1'b1;
    #1;
    tests++; if (dmem_req_valid !== 1'b1 || stall !== 1'b0) begin fails++; $display("FAIL bp_xfer got=%b/%b exp=1/0", dmem_req_valid, stall); end
    tick;
    idle_inputs;
    #1;
    tests++; if (dmem_req_valid !== 1'b0) begin fails++; $display("FAIL bp_single got=%b exp=0", dmem_req_valid); end
    tick;
    tests++; if (dmem_req_valid !== 1'b0) begin fails++; $display("FAIL bp_single2 got=%b exp=0", dmem_req_valid); end
    dmem_req_ready = 1'b0;
  endtask

  task automatic test_misaligned_lw;
    drive_op(1'b1, 1'b0, 3'd2, 32'h102, 32'h0, 5'd3, 1'b1);
`ifdef MEM_MISALIGN_TRAP_EN
    dmem_req_ready = 1'b1;
    #1;
    tests++; if (stall !== 1'b0 || dmem_req_valid !== 1'b0) begin fails++; $display("FAIL mis_noreq got=%b/%b exp=0/0", stall, dmem_req_valid); end
    tick;
    idle_inputs;
    tests++; if (fault5 !== 1'b1 || wb_en5 !== 1'b0 || dmem_req_valid !== 1'b0) begin fails++; $display("FAIL mis_fault got=%b/%b/%b exp=1/0/0", fault5, wb_en5, dmem_req_valid); end
    tick;
    tests++; if (fault5 !== 1'b0) begin fails++; $display("FAIL mis_fault_pulse got=%b exp=0", fault5); end
    dmem_req_ready = 1'b0;
`else
    dmem_req_ready = 1'b1;
    #1;
    tests++; if (stall !== 1'b1) begin fails++; $display("FAIL mis_stall got=%b exp=1", stall); end
    tick;
    tests++; if (dmem_req_valid !== 1'b1 || dmem_addr !== 32'h100 || dmem_be !== 4'hF) begin fails++; $display("FAIL mis_req got=%b/%h/%b exp=1/00000100/1111", dmem_req_valid, dmem_addr, dmem_be); end
    tick;
    dmem_req_ready = 1'b0; dmem_rsp_valid = 1'b1; dmem_rdata = 32'hCAFEF00D;
    #1;
    tests++; if (stall !== 1'b0) begin fails++; $display("FAIL mis_stall_rsp got=%b exp=0", stall); end
    tick;
    dmem_rsp_valid = 1'b0; idle_inputs;
    tests++; if (data_wb !== 32'hCAFEF00D || rd5 !== 5'd3 || wb_en5 !== 1'b1 || fault5 !== 1'b0)
      begin fails++; $display("FAIL mis_load got=%h/%0d/%b/%b exp=cafef00d/3/1/0", data_wb, rd5, wb_en5, fault5); end
`endif
    tick;
  endtask

  task automatic test_illegal;
    logic       lds [5];
    logic       sts [5];
    logic [2:0] fs  [5];
    lds = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    sts = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    fs  = '{3'd3, 3'd6, 3'd3, 3'd4, 3'd2};
    for (int k = 0; k < 5; k++) begin
      drive_op(lds[k], sts[k], fs[k], 32'h80, 32'h5, 5'd6, 1'b1);
      #1;
      tests++; if (stall !== 1'b0 || dmem_req_valid !== 1'b0) begin fails++; $display("FAIL ill%0d_noreq got=%b/%b exp=0/0", k, stall, dmem_req_valid); end
      tick;
      idle_inputs;
      tests++; if (fault5 !== 1'b1 || wb_en5 !== 1'b0) begin fails++; $display("FAIL ill%0d_fault got=%b/%b exp=1/0", k, fault5, wb_en5); end
      tick;
      tests++; if (fault5 !== 1'b0) begin fails++; $display("FAIL ill%0d_pulse got=%b exp=0", k, fault5); end
    end
  endtask

  task automatic test_reset_in_wait;
    drive_op(1'b1, 1'b0, 3'd2, 32'h200, 32'h0, 5'd4, 1'b1);
    dmem_req_ready = 1'b1;
    tick; tick;
    dmem_req_ready = 1'b0;
    rst = 1'b1;
    tick;
    tests++; if (stall !== 1'b0 || dmem_req_valid !== 1'b0) begin fails++; $display("FAIL rstw_outs got=%b/%b exp=0/0", stall, dmem_req_valid); end
    tests++; if ({data_wb, rd5, wb_en5, fault5} !== '0) begin fails++; $display("FAIL rstw_ps5 got=%h/%0d/%b/%b exp=0", data_wb, rd5, wb_en5, fault5); end
    rst = 1'b0; idle_inputs;
    dmem_rsp_valid = 1'b1; dmem_rdata = 32'hDEADBEEF;
    #1;
    tests++; if (stall !== 1'b0) begin fails++; $display("FAIL rstw_stall got=%b exp=0", stall); end
    tick;
    dmem_rsp_valid = 1'b0;
    tests++; if (data_wb !== 32'h0 || wb_en5 !== 1'b0) begin fails++; $display("FAIL rstw_discard got=%h/%b exp=0/0", data_wb, wb_en5); end
    drive_op(1'b0, 1'b0, 3'd0, 32'h55, 32'h0, 5'd2, 1'b1);
    tick;
    idle_inputs;
    tests++; if (data_wb !== 32'h55 || rd5 !== 5'd2 || wb_en5 !== 1'b1) begin fails++; $display("FAIL rstw_next got=%h/%0d/%b exp=55/2/1", data_wb, rd5, wb_en5); end
    tick;
  endtask

  task automatic test_random;
    logic [2:0]  ld_f3 [5];
    logic        ld, st, we, flt;
    logic [2:0]  f;
    logic [31:0] a, sd, rdat;
    logic [4:0]  r;
    int unsigned kind, rdly, sdly;
    ld_f3 = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    for (int i = 0; i < 40; i++) begin
      kind = $urandom_range(0, 5);
      a = $urandom; sd = $urandom; rdat = $urandom;
      r = (i % 8 == 0) ? 5'd0 : 5'($urandom_range(0, 31));
      we = 1'($urandom_range(0, 1));
      ld = 1'b0; st = 1'b0; f = 3'd0;
      case (kind)
        0: begin end
        1, 2: begin ld = 1'b1; f = ld_f3[$urandom_range(0, 4)]; end
        3, 4: begin st = 1'b1; f = 3'($urandom_range(0, 2)); end
        default: begin ld = 1'($urandom_range(0, 1)); st = ~ld | 1'($urandom_range(0, 1)); f = 3'($urandom_range(3, 7)); end
      endcase
      if (ld && !st && kind > 4 && f inside {3'd4, 3'd5}) f = 3'd7;
      flt = exp_fault(ld, st, f, a);
      drive_op(ld, st, f, a, sd, r, we);
      dmem_req_ready = 1'($urandom_range(0, 1));
      if (!ld && !st) begin
        #1;
        tests++; if (stall !== 1'b0 || dmem_req_valid !== 1'b0) begin fails++; $display("FAIL rnd%0d_nm_stall got=%b/%b exp=0/0", i, stall, dmem_req_valid); end
        tick;
        tests++; if (data_wb !== a || rd5 !== r || wb_en5 !== we || fault5 !== 1'b0)
          begin fails++; $display("FAIL rnd%0d_nm got=%h/%0d/%b/%b exp=%h/%0d/%b/0", i, data_wb, rd5, wb_en5, fault5, a, r, we); end
      end else if (flt) begin
        #1;
        tests++; if (stall !== 1'b0 || dmem_req_valid !== 1'b0) begin fails++; $display("FAIL rnd%0d_ill_stall got=%b/%b exp=0/0", i, stall, dmem_req_valid); end
        tick;
        tests++; if (fault5 !== 1'b1 || wb_en5 !== 1'b0) begin fails++; $display("FAIL rnd%0d_ill got=%b/%b exp=1/0", i, fault5, wb_en5); end
      end else begin
        rdly = $urandom_range(0, 2); sdly = $urandom_range(0, 2);
        dmem_req_ready = 1'b0;
        #1;
        tests++; if (stall !== 1'b1) begin fails++; $display("FAIL rnd%0d_stall0 got=%b exp=1", i, stall); end
        tick;
        for (int j = 0; j < int'(rdly); j++) begin
          dmem_rsp_valid = 1'($urandom_range(0, 1));
          #1;
          tests++; if (dmem_req_valid !== 1'b1 || dmem_addr !== (a & 32'hFFFFFFFC) || stall !== 1'b1)
            begin fails++; $display("FAIL rnd%0d_hold got=%b/%h/%b exp=1/%h/1", i, dmem_req_valid, dmem_addr, stall, a & 32'hFFFFFFFC); end
          tick;
        end
        dmem_rsp_valid = 1'b0; dmem_req_ready = 1'b1;
        #1;
        tests++; if (dmem_req_valid !== 1'b1 || dmem_we !== st || dmem_addr !== (a & 32'hFFFFFFFC) || stall !== ld)
          begin fails++; $display("FAIL rnd%0d_req got=%b/%b/%h/%b exp=1/%b/%h/%b", i, dmem_req_valid, dmem_we, dmem_addr, stall, st, a & 32'hFFFFFFFC, ld); end
        if (st) begin
          tests++; if (dmem_be !== exp_be(f, a) || dmem_wdata !== exp_wdata(f, sd))
            begin fails++; $display("FAIL rnd%0d_lanes got=%b/%h exp=%b/%h", i, dmem_be, dmem_wdata, exp_be(f, a), exp_wdata(f, sd)); end
        end
        tick;
        dmem_req_ready = 1'b0;
        if (st) begin
          idle_inputs;
          #1;
          tests++; if (wb_en5 !== 1'b0 || dmem_req_valid !== 1'b0) begin fails++; $display("FAIL rnd%0d_st_done got=%b/%b exp=0/0", i, wb_en5, dmem_req_valid); end
        end else begin
          for (int j = 0; j < int'(sdly); j++) begin
            #1;
            tests++; if (stall !== 1'b1 || dmem_req_valid !== 1'b0 || wb_en5 !== 1'b0) begin fails++; $display("FAIL rnd%0d_wait got=%b/%b/%b exp=1/0/0", i, stall, dmem_req_valid, wb_en5); end
            tick;
          end
          dmem_rsp_valid = 1'b1; dmem_rdata = rdat;
          #1;
          tests++; if (stall !== 1'b0) begin fails++; $display("FAIL rnd%0d_rsp_stall got=%b exp=0", i, stall); end
          tick;
          dmem_rsp_valid = 1'b0; idle_inputs;
          tests++; if (data_wb !== exp_load(f, a, rdat) || rd5 !== r || wb_en5 !== we)
            begin fails++; $display("FAIL rnd%0d_ld f3=%0d a=%h got=%h/%0d/%b exp=%h/%0d/%b", i, f, a, data_wb, rd5, wb_en5, exp_load(f, a, rdat), r, we); end
        end
      end
      idle_inputs; dmem_req_ready = 1'b0; dmem_rsp_valid = 1'b0;
    end
    tick;
  endtask

  initial begin
    test_reset;
    test_non_mem;
    test_sb;
    test_lh;
    test_backpressure;
    test_misaligned_lw;
    test_illegal;
    test_reset_in_wait;
    test_random;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
